seg_readback: RTL and testbench

// - Inverse of the hex-to-7-segment path: watches a multiplexed, active-low 7-segment bus
//   (segment pattern + one-hot digit select) and recovers the displayed hex digits.
// - Debounces each pattern, decodes it back to 4 bits and assembles one full scan frame.
// - Presents the frame on a valid/ready handshake; used as a display readback/self-check

---
 rtl/seg_readback_if.sv | 24 ++
 rtl/seg_readback.sv | 143 ++++++++++++++
 tb/tb_seg_readback.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_readback_if.sv
// Bus bundle for the 7-segment readback block: scanned segment inputs,
// recovered frame outputs and the frame valid/ready handshake.
interface seg_readback_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              segments_in;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic [NUM_DIGITS-1:0]   blank_out;
  logic [NUM_DIGITS-1:0]   err_out;
  logic                    valid_out;
  logic                    ready_in;
  logic                    overrun;

  modport slave (
    input  segments_in, digit_sel, ready_in,
    output value_out, blank_out, err_out, valid_out, overrun
  );

  modport master (
    output segments_in, digit_sel, ready_in,
    input  value_out, blank_out, err_out, valid_out, overrun
  );
endinterface

// File: rtl/seg_readback.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus: debounces each
// scanned pattern, decodes it and presents a complete scan frame on valid/ready.
module seg_readback #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic            clock,
  input logic            resetn,
  seg_readback_if.slave  bus
);

  localparam int                CNT_W    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ARM  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [0:0]        S_COLLECT = 1'b0;
  localparam logic [0:0]        S_HOLD    = 1'b1;

  // {err, blank, value}; exact match against the active-low hex font
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] res;
    res = 6'b00_0000;
    case (seg)
      7'h40: res = 6'h00;
      7'h79: res = 6'h01;
      7'h24: res = 6'h02;
      7'h30: res = 6'h03;
      7'h19: res = 6'h04;
      7'h12: res = 6'h05;
      7'h02: res = 6'h06;
      7'h78: res = 6'h07;
      7'h00: res = 6'h08;
      7'h18: res = 6'h09;
      7'h08: res = 6'h0A;
      7'h03: res = 6'h0B;
      7'h46: res = 6'h0C;
      7'h21: res = 6'h0D;
      7'h06: res = 6'h0E;
      7'h0E: res = 6'h0F;
      7'h7F: res = 6'b01_0000;
      default: res = 6'b10_0000;
    endcase
    return res;
  endfunction

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  logic [NUM_DIGITS-1:0]   r_sel_p0;
  logic [6:0]              r_seg_p0;
  logic [CNT_W-1:0]        r_cnt;
  logic [0:0]              r_state;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_overrun;

  logic                    w_same;
  logic                    w_legal;
  logic                    w_commit;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [NUM_DIGITS-1:0]   w_mask_nxt;
  logic [5:0]              w_dec;
  logic                    w_handshake;

  always_comb begin
    w_same      = (bus.digit_sel == r_sel_p0) && (bus.segments_in == r_seg_p0);
    w_legal     = is_onehot(bus.digit_sel);
    w_commit    = w_same && w_legal && (r_cnt == CNT_ARM);
    w_cnt_nxt   = '0;
    if (w_same && w_legal)
      w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_mask_nxt  = r_mask | r_sel_p0;
    w_dec       = decode_seg(r_seg_p0);
    w_handshake = (r_state == S_HOLD) && bus.ready_in;
  end

  // Stage p0: sample register and dwell counter, running in every state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sel_p0 <= '0;
      r_seg_p0 <= '0;
      r_cnt    <= '0;
    end else begin
      r_sel_p0 <= bus.digit_sel;
      r_seg_p0 <= bus.segments_in;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Frame assembly: slots only move in COLLECT, so HOLD freezes the outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_value <= '0;
      r_blank <= '0;
      r_err   <= '0;
    end else if (w_commit && (r_state == S_COLLECT)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_sel_p0[i]) begin
          r_value[4*i +: 4] <= w_dec[3:0];
          r_blank[i]        <= w_dec[4];
          r_err[i]          <= w_dec[5];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_COLLECT;
      r_mask    <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_commit) begin
            r_mask <= w_mask_nxt;
            if (&w_mask_nxt)
              r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // a commit landing on the handshake edge is lost as well
          if (w_commit)
            r_overrun <= 1'b1;
          if (w_handshake) begin
            r_state <= S_COLLECT;
            r_mask  <= '0;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign bus.value_out = r_value;
  assign bus.blank_out = r_blank;
  assign bus.err_out   = r_err;
  assign bus.valid_out = (r_state == S_HOLD);
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_seg_readback.sv
// Bench for seg_readback: directed scenarios plus randomized dwells, all checked
// each cycle against a run-length / frame-level reference model.
module tb_seg_readback;

  localparam int ND = 4;
  localparam int SC = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  seg_readback_if #(.NUM_DIGITS(ND)) bus ();

  seg_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [ND-1:0]   m_prev_sel = '0;
  logic [6:0]      m_prev_seg = '0;
  int              m_run      = 1;
  logic [ND-1:0]   m_mask     = '0;
  logic [3:0]      m_val [ND] = '{default: 4'h0};
  logic [ND-1:0]   m_blank    = '0;
  logic [ND-1:0]   m_err      = '0;
  logic            m_hold     = 1'b0;
  logic            m_ovr      = 1'b0;

  int              n_valid    = 0;
  logic [15:0]     last_val   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_value();
    logic [15:0] v;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = m_val[i];
    return v;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_prev_sel = '0; m_prev_seg = '0; m_run = 1; m_mask = '0;
      for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
      m_blank = '0; m_err = '0; m_hold = 1'b0; m_ovr = 1'b0;
    end else begin
      logic [ND-1:0] s_sel;
      logic [6:0]    s_seg;
      logic          commit;
      s_sel = bus.digit_sel;
      s_seg = bus.segments_in;
      if (s_sel == m_prev_sel && s_seg == m_prev_seg) m_run++;
      else m_run = 1;
      commit = ($countones(s_sel) == 1) && (m_run == SC);
      if (m_hold) begin
        if (commit) m_ovr = 1'b1;
        if (bus.ready_in) begin m_hold = 1'b0; m_mask = '0; end
      end else if (commit) begin
        for (int d = 0; d < ND; d++) begin
          if (s_sel[d]) begin
            m_val[d] = 4'h0; m_blank[d] = 1'b0; m_err[d] = 1'b1;
            if (s_seg == 7'h7F) begin m_blank[d] = 1'b1; m_err[d] = 1'b0; end
            for (int k = 0; k < 16; k++)
              if (font[k] == s_seg) begin m_val[d] = 4'(k); m_err[d] = 1'b0; end
          end
        end
        m_mask = m_mask | s_sel;
        if (&m_mask) m_hold = 1'b1;
      end
      m_prev_sel = s_sel;
      m_prev_seg = s_seg;
    end
  end

  task automatic cycle(input logic [ND-1:0] sel, input logic [6:0] seg, input logic rdy);
    bus.digit_sel   = sel;
    bus.segments_in = seg;
    bus.ready_in    = rdy;
    @(negedge clock);
    chk("value", bus.value_out, m_value());
    chk("blank", bus.blank_out, m_blank);
    chk("err",   bus.err_out,   m_err);
    chk("valid", bus.valid_out, m_hold);
    chk("ovr",   bus.overrun,   m_ovr);
    if (bus.valid_out) begin n_valid++; last_val = bus.value_out; end
  endtask

  task automatic dwell(input logic [ND-1:0] sel, input logic [6:0] seg, input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(sel, seg, rdy);
  endtask

  task automatic rst_pulse();
    resetn = 1'b0;
    cycle('0, 7'h00, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.digit_sel = '0; bus.segments_in = '0; bus.ready_in = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cycle(4'($urandom), 7'($urandom), 1'($urandom));
      chk("rst_valid", bus.valid_out, 0);
      chk("rst_value", bus.value_out, 0);
    end
    resetn = 1'b1;

    dwell(4'b0001, 7'h79, 1'b1, 3);
    chk("deb_short", bus.value_out[3:0], 4'h0);
    dwell(4'b0001, 7'h24, 1'b1, 4);
    chk("deb_commit", bus.value_out[3:0], 4'h2);

    rst_pulse();
    n_valid = 0;
    dwell(4'b0001, 7'h12, 1'b1, 6);
    dwell(4'b0010, 7'h08, 1'b1, 6);
    dwell(4'b0100, 7'h0E, 1'b1, 6);
    dwell(4'b1000, 7'h40, 1'b1, 6);
    dwell(4'b0000, 7'h7F, 1'b1, 4);
    chk("frm_vcount", n_valid, 1);
    chk("frm_value", last_val, 16'h0FA5);
    chk("frm_blank", bus.blank_out, 0);
    chk("frm_err", bus.err_out, 0);

    rst_pulse();
    dwell(4'b0010, 7'h7F, 1'b0, 5);
    dwell(4'b0100, 7'h55, 1'b0, 5);
    chk("blank_bit", bus.blank_out, 4'b0010);
    chk("err_bit", bus.err_out, 4'b0100);
    chk("be_nibbles", bus.value_out[11:4], 8'h00);
    dwell(4'b0001, 7'h19, 1'b0, 5);
    dwell(4'b1000, 7'h02, 1'b0, 5);
    chk("bp_valid", bus.valid_out, 1);
    chk("bp_value", bus.value_out, 16'h6004);
    dwell(4'b0001, 7'h30, 1'b0, 5);
    chk("bp_frozen", bus.value_out, 16'h6004);
    chk("bp_ovr", bus.overrun, 1);
    chk("bp_still", bus.valid_out, 1);
    dwell(4'b0001, 7'h30, 1'b1, 1);
    chk("bp_hs", bus.valid_out, 0);
    chk("bp_ovr_sticky", bus.overrun, 1);

    rst_pulse();
    dwell(4'b0011, 7'h79, 1'b1, 10);
    chk("ill_value", bus.value_out, 0);
    chk("ill_err", bus.err_out, 0);
    chk("ill_valid", bus.valid_out, 0);

    dwell(4'b0001, 7'h79, 1'b0, 6);
    dwell(4'b0010, 7'h24, 1'b0, 6);
    chk("mid_partial", bus.value_out[7:0], 8'h21);
    rst_pulse();
    chk("mid_cleared", bus.value_out, 0);
    n_valid = 0;
    dwell(4'b0100, 7'h30, 1'b0, 6);
    dwell(4'b1000, 7'h19, 1'b0, 6);
    chk("mid_novalid", n_valid, 0);
    dwell(4'b0001, 7'h79, 1'b0, 6);
    dwell(4'b0010, 7'h24, 1'b0, 6);
    chk("mid_valid", bus.valid_out, 1);
    chk("mid_value", bus.value_out, 16'h4321);

    for (int t = 0; t < 300; t++) begin
      logic [ND-1:0] sel;
      logic [6:0]    seg;
      int            len;
      int            pick;
      if ($urandom_range(39) == 0) rst_pulse();
      if ($urandom_range(99) < 85) sel = 4'(1 << $urandom_range(3));
      else sel = 4'($urandom);
      pick = $urandom_range(99);
      if (pick < 60) seg = font[$urandom_range(15)];
      else if (pick < 75) seg = 7'h7F;
      else seg = 7'($urandom);
      len = $urandom_range(7, 1);
      for (int i = 0; i < len; i++) cycle(sel, seg, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
